gpio_in_conditioner: RTL
========================

// Module: gpio_in_conditioner
// PURPOSE
//  Input conditioning stage between the GPIO pad ring's receive outputs and the SoC's i_gpio input.
//  Per bit: synchronizes the asynchronous pad value, debounces it with a hold counter, and emits
//  single-cycle rise/fall pulses. Pulses feed sticky W1C interrupt status and one summary IRQ line.
// PARAMETERS
//  WIDTH            32   number of GPIO bits
//  SYNC_STAGES      2    synchronizer flops per bit (>=2)
//  DEBOUNCE_CYCLES  16   consecutive mismatch cycles before the stable level flips (>=1);
//                        counter width = $clog2(DEBOUNCE_CYCLES+1)
//  INIT_VAL         0    reset value (1 bit, replicated) of sync chain and stable level
// PORTS
//  clk           in   1      system clock (single clock domain)
//  reset         in   1      synchronous, active-high reset
//  i_pad_c       in   WIDTH  raw pad receive values, asynchronous to clk
//  o_gpio_in     out  WIDTH  debounced stable level, to SoC i_gpio
//  o_rise        out  WIDTH  1-cycle pulse on stable 0->1
//  o_fall        out  WIDTH  1-cycle pulse on stable 1->0
//  i_rise_en     in   WIDTH  per-bit enable for rise -> status
//  i_fall_en     in   WIDTH  per-bit enable for fall -> status
//  i_irq_clear   in   WIDTH  per-bit write-1-to-clear of status (1-cycle strobe)
//  o_irq_status  out  WIDTH  sticky edge status
//  o_irq         out  1      |o_irq_status (combinational from status flops)
// BEHAVIOUR
//  Reset (sync, active-high):
//   - Sync chain and o_gpio_in reset to {WIDTH{INIT_VAL}}.
//   - Counters, o_rise, o_fall and o_irq_status reset to 0; o_irq therefore reads 0.
//   - Asserting reset mid-debounce discards the count. No pulse is generated by reset itself.
//  Sync: sync_q = last flop of the SYNC_STAGES chain.
//  Debounce, per bit, each cycle:
//   - sync_q == stable: cnt <= 0.
//   - Mismatch and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//   - Mismatch and cnt == DEBOUNCE_CYCLES-1: stable <= sync_q, cnt <= 0.
//  Latency: counting the first clock edge that samples the new pad value as edge 1, o_gpio_in
//   changes after edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 18).
//  Glitch rejection: any return to the stable value before the count completes clears cnt;
//   o_gpio_in does not change.
//  DEBOUNCE_CYCLES==1: stable follows sync_q one cycle later (filtering disabled).
//  Edge pulses: o_rise/o_fall are registered and assert in the same cycle o_gpio_in takes its
//   new value, for exactly 1 cycle. o_rise and o_fall are never both high for the same bit.
//  Status, per bit:
//   - Set when (o_rise & i_rise_en) | (o_fall & i_fall_en) is asserted in a cycle; visible the next cycle.
//   - Cleared by i_irq_clear.
//   - Set and clear in the same cycle: set wins.
//   - Enables are gated at set time only; clearing an enable does not clear existing status.
//  Post-reset mismatch: a pad held opposite to INIT_VAL at reset release debounces normally and
//   produces one edge pulse after the standard latency.
// CONFIGURATION
//  GPIO_IN_RUNTIME_BYPASS_EN defined:
//   - Adds port i_bypass (in, WIDTH).
//   - Bits with i_bypass=1 skip the debounce: stable <= sync_q every cycle, cnt held at 0.
//   - Edge pulses and status behave identically.
//   - Changing i_bypass 1->0 with a pending mismatch restarts the count from 0.
//  Macro undefined: port absent; all bits always debounced.
// TESTING
//  1. Reset, pad=0, raise bit0 and hold -> o_gpio_in[0]=1 after edge 18; o_rise[0] high exactly
//     1 cycle; o_irq_status stays 0 with i_rise_en=0.
//  2. i_rise_en[5]=1; pad5 rises with a 10-cycle glitch, then returns -> no change, no pulse.
//     Then hold 30 cycles -> status[5]=1, o_irq=1.
//  3. status[3]=1; in the same cycle pulse i_irq_clear[3] and a new enabled fall on bit3 -> status
//     stays 1. Clear alone next cycle -> 0; o_irq drops with it.
//  4. Pad bit7 toggles; assert reset at cnt=8 -> outputs return to reset values, no pulse.
//     Pad still high after release -> rise after edge 18.
//  5. DEBOUNCE_CYCLES=1 build: 1-cycle-wide pad pulse (clk-aligned) -> o_rise then o_fall,
//     consecutive single-cycle pulses.
//  6. GPIO_IN_RUNTIME_BYPASS_EN, i_bypass[2]=1: pad2 rises -> o_gpio_in[2] changes after edge 3;
//     other bits still need 18.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// GPIO receive conditioning: per-bit synchronizer, hold-counter debounce, edge pulses, sticky W1C IRQ status.
// Optional GPIO_IN_RUNTIME_BYPASS_EN adds i_bypass to skip debounce on selected bits.
module gpio_in_conditioner #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        INIT_VAL        = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pad_c,
`ifdef GPIO_IN_RUNTIME_BYPASS_EN
    input  logic [WIDTH-1:0] i_bypass,
`endif
    output logic [WIDTH-1:0] o_gpio_in,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_irq_clear,
    output logic [WIDTH-1:0] o_irq_status,
    output logic             o_irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [CNT_W-1:0] cnt_r   [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] bypass;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] set_status;
    logic [WIDTH-1:0] status_nxt;

`ifdef GPIO_IN_RUNTIME_BYPASS_EN
    assign bypass = i_bypass;
`else
    assign bypass = '0;
`endif

    assign sync_q = sync_r[SYNC_STAGES-1];

    // Synchronizer chain for the asynchronous pad values
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_r[s] <= {WIDTH{INIT_VAL}};
            end
        end else begin
            sync_r[0] <= i_pad_c;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Debounce decision: flip the stable level after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        flip = '0;
        for (int b = 0; b < int'(WIDTH); b++) begin
            cnt_nxt[b] = '0;
            if (sync_q[b] != o_gpio_in[b]) begin
                if (bypass[b] || (cnt_r[b] == CNT_LAST)) begin
                    flip[b] = 1'b1;
                end else begin
                    cnt_nxt[b] = cnt_r[b] + CNT_W'(1);
                end
            end
        end
        stable_nxt = o_gpio_in ^ flip;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                cnt_r[b] <= '0;
            end
        end else begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                cnt_r[b] <= cnt_nxt[b];
            end
        end
    end

    // Stable level and edge pulses share a register stage so pulses align with the new level
    always_ff @(posedge clk) begin
        if (reset) begin
            o_gpio_in <= {WIDTH{INIT_VAL}};
            o_rise    <= '0;
            o_fall    <= '0;
        end else begin
            o_gpio_in <= stable_nxt;
            o_rise    <= flip & sync_q;
            o_fall    <= flip & ~sync_q;
        end
    end

    // Sticky status: a set in the same cycle as a clear takes priority
    always_comb begin
        set_status = (o_rise & i_rise_en) | (o_fall & i_fall_en);
        status_nxt = (o_irq_status & ~i_irq_clear) | set_status;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_irq_status <= '0;
        end else begin
            o_irq_status <= status_nxt;
        end
    end

    assign o_irq = |o_irq_status;

endmodule
